mv_good_seq: RTL and testbench
==============================

MV_GOOD_SEQ -- requirements
Module: mv_good_seq

Interface
REQ-001 Parameter NUM_BRD, default 2, meaning number of amplifier boards sequenced; legal range 1..4.
REQ-002 Parameter CNT_WIDTH, default 24, meaning width of each per-board delay counter.
REQ-003 Parameter DELAY_CNT, default 24'd1966080, meaning motor-voltage settle delay in sysclk cycles (40 ms at 49.152 MHz); legal range 2..2^CNT_WIDTH-1.
REQ-004 sysclk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  meaning asynchronous, active-high reset.
REQ-006 mv_good  input  NUM_BRD  meaning per-board motor voltage good, already synchronous to sysclk.
REQ-007 pwr_enable  input  NUM_BRD  meaning per-board motor power enable, as commanded by host.
REQ-008 clear_fault  input  1  meaning single-cycle pulse (host power-enable command) that clears latched faults.
REQ-009 mv_amp_disable  output  NUM_BRD  meaning per-board amplifier disable, 1 = amplifiers held off.
REQ-010 mv_fault  output  NUM_BRD  meaning per-board latched fault: voltage lost while running.
REQ-011 mv_fault_any  output  1  meaning OR of mv_fault.
REQ-012 mv_ready_all  output  1  meaning 1 only when every board has mv_amp_disable = 0.
REQ-013 mv_state  output  2*NUM_BRD  meaning per-board state code, board i in bits [2i+1:2i].

Function
REQ-014 Each board shall run an independent 4-state machine: IDLE=2'b00, WAIT=2'b01, ON=2'b10, FAULT=2'b11.
REQ-015 Each board shall have an independent counter of CNT_WIDTH bits.
REQ-016 IDLE: the counter shall be held at 0.
REQ-017 IDLE: if mv_good[i]=1 and pwr_enable[i]=1 at an edge, the state shall be WAIT after that edge and the counter 0.
REQ-018 WAIT: if mv_good[i]=0 or pwr_enable[i]=0, the next state shall be IDLE and the counter 0; no fault is flagged.
REQ-019 WAIT otherwise: if counter = DELAY_CNT-1, the next state shall be ON; else the counter shall increment by 1.
REQ-020 Latency: with inputs held high, the state shall reach ON exactly DELAY_CNT edges after the edge that entered WAIT.
REQ-021 ON: if pwr_enable[i]=0, the next state shall be IDLE; this has priority over mv_good.
REQ-022 ON: if pwr_enable[i]=1 and mv_good[i]=0, the next state shall be FAULT.
REQ-023 FAULT: the state shall be held until clear_fault=1, then the next state shall be IDLE regardless of other inputs.
REQ-024 Re-entry to WAIT from IDLE after a fault clear shall take at least one further cycle.
REQ-025 clear_fault in IDLE, WAIT or ON shall have no effect.
REQ-026 mv_amp_disable[i] shall be 0 iff state=ON.
REQ-027 mv_fault[i] shall be 1 iff state=FAULT.
REQ-028 mv_amp_disable, mv_fault, mv_fault_any, mv_ready_all and mv_state shall be decoded from registered state only, with no input-to-output combinational path.
REQ-029 The counter shall never wrap; it shall be reset to 0 on every exit from WAIT.
REQ-030 Boards shall not interact; simultaneous events on different boards shall be handled independently in the same cycle.

Reset
REQ-031 While reset=1, all states shall be IDLE and all counters 0, immediately and without waiting for a clock edge.
REQ-032 Output values during reset: mv_amp_disable all 1, mv_fault 0, mv_fault_any 0, mv_ready_all 0, mv_state 0.
REQ-033 Reset asserted during WAIT, ON or FAULT shall abort to IDLE with no fault retained.
REQ-034 After reset deasserts, the first possible WAIT entry shall be the first rising edge with mv_good=pwr_enable=1.

Verification
REQ-035 NUM_BRD=2, DELAY_CNT=8; board 1 mv_good and pwr_enable raised at edge k -> mv_state[1:0]=01 after k; mv_amp_disable[1]=0 after edge k+8 and not before; mv_ready_all stays 0 (board 2 idle).
REQ-036 Board 1 in WAIT with counter=5; mv_good pulses low for 1 cycle -> IDLE with counter 0, mv_fault=0; the full 8-cycle delay restarts from the next entry.
REQ-037 Board 2 ON; mv_good[2] drops with pwr_enable[2]=1 -> mv_state[3:2]=11, mv_fault=2'b10, mv_fault_any=1, mv_amp_disable[2]=1; a clear_fault pulse -> IDLE next edge; re-enable -> ON 8 edges after re-entering WAIT.
REQ-038 Board 1 ON; pwr_enable[1] and mv_good[1] drop on the same edge -> IDLE, mv_fault[1]=0.
REQ-039 Both boards ON, then reset asserted between clock edges -> outputs immediately mv_amp_disable=2'b11, mv_state=0, mv_ready_all=0.
REQ-040 NUM_BRD=4, DELAY_CNT=2; staggered enables on all four boards -> each board reaches ON 2 edges after its own WAIT entry; mv_ready_all=1 only after the last board reaches ON.

Source files
------------

// File: rtl/mv_good_seq.sv
// Per-board motor-voltage power-up sequencer: waits for a settle delay after
// mv_good and pwr_enable are both high before releasing the amplifiers, and latches a fault on voltage loss.
module mv_good_seq #(
  parameter int unsigned          NUM_BRD   = 2,
  parameter int unsigned          CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] DELAY_CNT = 24'd1966080
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_BRD-1:0]   mv_good,
  input  logic [NUM_BRD-1:0]   pwr_enable,
  input  logic                 clear_fault,
  output logic [NUM_BRD-1:0]   mv_amp_disable,
  output logic [NUM_BRD-1:0]   mv_fault,
  output logic                 mv_fault_any,
  output logic                 mv_ready_all,
  output logic [2*NUM_BRD-1:0] mv_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ON    = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // WAIT is entered with the counter at 0, so ON is reached DELAY_CNT edges after entry
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = DELAY_CNT - 1'b1;

  genvar i;
  generate
    for (i = 0; i < NUM_BRD; i++) begin : g_brd
      state_t               state_q, state_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // The counter only advances while in WAIT; every other path forces it back to 0
      always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
          ST_IDLE: begin
            if (mv_good[i] && pwr_enable[i]) state_d = ST_WAIT;
          end
          ST_WAIT: begin
            if (!mv_good[i] || !pwr_enable[i]) state_d = ST_IDLE;
            else if (cnt_q == LAST_CNT)        state_d = ST_ON;
            else                               cnt_d   = cnt_q + 1'b1;
          end
          ST_ON: begin
            if (!pwr_enable[i])  state_d = ST_IDLE;
            else if (!mv_good[i]) state_d = ST_FAULT;
          end
          ST_FAULT: begin
            if (clear_fault) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      assign mv_state[2*i +: 2]  = state_q;
      assign mv_amp_disable[i]   = (state_q != ST_ON);
      assign mv_fault[i]         = (state_q == ST_FAULT);
    end
  endgenerate

  assign mv_fault_any = |mv_fault;
  assign mv_ready_all = ~|mv_amp_disable;

endmodule

// File: tb/tb_mv_good_seq.sv
// Bench for mv_good_seq: a 2-board/8-cycle instance and a 4-board/2-cycle
// instance driven from a vector table, with a scoreboard queue of expected outputs.
module tb_mv_good_seq;

  typedef struct {
    int          tag;
    int unsigned reps;
    logic        dut;
    logic [3:0]  good;
    logic [3:0]  en;
    logic        clr;
    logic [7:0]  exp_state;
    logic [3:0]  exp_dis;
    logic [3:0]  exp_flt;
  } vec_t;

  typedef struct {
    int         tag;
    logic       dut;
    logic [7:0] st;
    logic [3:0] dis;
    logic [3:0] flt;
    logic       any;
    logic       all;
  } exp_t;

  logic sysclk;
  logic reset;

  logic [1:0] a_good, a_en;
  logic       a_clr;
  logic [1:0] a_dis, a_flt;
  logic       a_any, a_all;
  logic [3:0] a_state;

  logic [3:0] b_good, b_en;
  logic       b_clr;
  logic [3:0] b_dis, b_flt;
  logic       b_any, b_all;
  logic [7:0] b_state;

  int   tests_run;
  int   tests_failed;
  vec_t vecs[$];
  exp_t sb[$];

  mv_good_seq #(.NUM_BRD(2), .CNT_WIDTH(24), .DELAY_CNT(24'd8)) dut_a (
    .sysclk        (sysclk),
    .reset         (reset),
    .mv_good       (a_good),
    .pwr_enable    (a_en),
    .clear_fault   (a_clr),
    .mv_amp_disable(a_dis),
    .mv_fault      (a_flt),
    .mv_fault_any  (a_any),
    .mv_ready_all  (a_all),
    .mv_state      (a_state)
  );

  mv_good_seq #(.NUM_BRD(4), .CNT_WIDTH(24), .DELAY_CNT(24'd2)) dut_b (
    .sysclk        (sysclk),
    .reset         (reset),
    .mv_good       (b_good),
    .pwr_enable    (b_en),
    .clear_fault   (b_clr),
    .mv_amp_disable(b_dis),
    .mv_fault      (b_flt),
    .mv_fault_any  (b_any),
    .mv_ready_all  (b_all),
    .mv_state      (b_state)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input int unsigned reps, input logic dut, input logic [3:0] good,
                        input logic [3:0] en, input logic clr, input logic [7:0] st,
                        input logic [3:0] dis, input logic [3:0] flt);
    vec_t v;
    v.tag = vecs.size(); v.reps = reps; v.dut = dut; v.good = good; v.en = en; v.clr = clr;
    v.exp_state = st; v.exp_dis = dis; v.exp_flt = flt;
    vecs.push_back(v);
  endtask

  task automatic pushExp(input int tag, input logic dut, input logic [7:0] st,
                         input logic [3:0] dis, input logic [3:0] flt);
    exp_t e;
    e.tag = tag; e.dut = dut; e.st = st; e.dis = dis; e.flt = flt;
    e.any = |flt;
    e.all = (dis == 4'b0000);
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (row %0d): got %b, expected %b", name, tag, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.dut == 1'b0) begin
      cmp("a_state", e.tag, {4'b0, a_state}, e.st);
      cmp("a_amp_disable", e.tag, {6'b0, a_dis}, {4'b0, e.dis});
      cmp("a_fault", e.tag, {6'b0, a_flt}, {4'b0, e.flt});
      cmp("a_fault_any", e.tag, {7'b0, a_any}, {7'b0, e.any});
      cmp("a_ready_all", e.tag, {7'b0, a_all}, {7'b0, e.all});
    end else begin
      cmp("b_state", e.tag, b_state, e.st);
      cmp("b_amp_disable", e.tag, {4'b0, b_dis}, {4'b0, e.dis});
      cmp("b_fault", e.tag, {4'b0, b_flt}, {4'b0, e.flt});
      cmp("b_fault_any", e.tag, {7'b0, b_any}, {7'b0, e.any});
      cmp("b_ready_all", e.tag, {7'b0, b_all}, {7'b0, e.all});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int r = 0; r < int'(v.reps); r++) begin
      if (v.dut == 1'b0) begin
        a_good = v.good[1:0]; a_en = v.en[1:0]; a_clr = v.clr;
      end else begin
        b_good = v.good; b_en = v.en; b_clr = v.clr;
      end
      pushExp(v.tag, v.dut, v.exp_state, v.exp_dis, v.exp_flt);
      @(posedge sysclk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    vec_t v;
    tests_run    = 0;
    tests_failed = 0;

    // Instance A (2 boards, 8-cycle delay): reps, dut, good, en, clr, state, disable, fault
    addVec(2, 0, 4'b00, 4'b00, 0, 8'b0000, 4'b11, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(7, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0010, 4'b10, 4'b00);
    addVec(1, 0, 4'b00, 4'b00, 0, 8'b0000, 4'b11, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(5, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(1, 0, 4'b00, 4'b01, 0, 8'b0000, 4'b11, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(7, 0, 4'b01, 4'b01, 0, 8'b0001, 4'b11, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0010, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 0, 8'b0110, 4'b10, 4'b00);
    addVec(7, 0, 4'b11, 4'b11, 0, 8'b0110, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 0, 8'b1010, 4'b00, 4'b00);
    addVec(1, 0, 4'b01, 4'b11, 0, 8'b1110, 4'b10, 4'b10);
    addVec(3, 0, 4'b11, 4'b11, 0, 8'b1110, 4'b10, 4'b10);
    addVec(1, 0, 4'b11, 4'b11, 1, 8'b0010, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 0, 8'b0110, 4'b10, 4'b00);
    addVec(7, 0, 4'b11, 4'b11, 0, 8'b0110, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 0, 8'b1010, 4'b00, 4'b00);
    addVec(1, 0, 4'b01, 4'b01, 0, 8'b0010, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 1, 8'b0110, 4'b10, 4'b00);
    addVec(3, 0, 4'b11, 4'b11, 1, 8'b0110, 4'b10, 4'b00);
    addVec(4, 0, 4'b11, 4'b11, 0, 8'b0110, 4'b10, 4'b00);
    addVec(1, 0, 4'b11, 4'b11, 0, 8'b1010, 4'b00, 4'b00);
    // Instance B (4 boards, 2-cycle delay): staggered enables, then simultaneous events
    addVec(1, 1, 4'b0001, 4'b0001, 0, 8'b0000_0001, 4'b1111, 4'b0000);
    addVec(1, 1, 4'b0011, 4'b0011, 0, 8'b0000_0101, 4'b1111, 4'b0000);
    addVec(1, 1, 4'b0111, 4'b0111, 0, 8'b0001_0110, 4'b1110, 4'b0000);
    addVec(1, 1, 4'b1111, 4'b1111, 0, 8'b0101_1010, 4'b1100, 4'b0000);
    addVec(1, 1, 4'b1111, 4'b1111, 0, 8'b0110_1010, 4'b1000, 4'b0000);
    addVec(1, 1, 4'b1111, 4'b1111, 0, 8'b1010_1010, 4'b0000, 4'b0000);
    addVec(1, 1, 4'b1101, 4'b1110, 0, 8'b1010_1100, 4'b0011, 4'b0010);

    a_good = '0; a_en = '0; a_clr = 1'b0;
    b_good = '0; b_en = '0; b_clr = 1'b0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    #1;
    pushExp(-1, 0, 8'h00, 4'b0011, 4'b0000); checkOutput();
    pushExp(-1, 1, 8'h00, 4'b1111, 4'b0000); checkOutput();
    @(posedge sysclk);
    #1 reset = 1'b0;

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Instance A is fully ON here; reset between edges must clear outputs without a clock
    #3 reset = 1'b1;
    #1;
    pushExp(-2, 0, 8'h00, 4'b0011, 4'b0000); checkOutput();
    pushExp(-2, 1, 8'h00, 4'b1111, 4'b0000); checkOutput();
    @(posedge sysclk);
    #1;
    pushExp(-3, 0, 8'h00, 4'b0011, 4'b0000); checkOutput();
    #2 reset = 1'b0;

    // Inputs still high: first edge after release enters WAIT, ON 8 edges later
    v.tag = -4; v.dut = 0; v.good = 4'b11; v.en = 4'b11; v.clr = 0;
    v.reps = 1; v.exp_state = 8'b0101; v.exp_dis = 4'b11; v.exp_flt = 4'b00;
    applyStimulus(v);
    v.reps = 7;
    applyStimulus(v);
    v.reps = 1; v.exp_state = 8'b1010; v.exp_dis = 4'b00;
    applyStimulus(v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
